updown_counter: RTL and testbench

//   Parametrised successor to the basic counter: modulo-N up/down counter with variable step,

---
 rtl/updown_counter_pkg.sv | 29 ++
 rtl/updown_counter_next.sv | 62 ++++++
 rtl/updown_counter.sv | 119 +++++++++++
 tb/tb_updown_counter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// Shared types for the modulo-N up/down counter: count direction, the decoded per-cycle
// operation, and the priority decode helper.
package updown_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_COUNT
    } op_e;

    // clear beats load beats en; anything lower in the same cycle is dropped
    function automatic op_e decode_op(input logic clear, input logic load, input logic en);
        if (clear) begin
            return OP_CLEAR;
        end else if (load) begin
            return OP_LOAD;
        end else if (en) begin
            return OP_COUNT;
        end
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count arithmetic for an enabled up/down step, with wrap or clamp at the
// limits and the matching overflow/underflow flags. Holds the count for any other operation.
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned MAX_COUNT   = 2**COUNT_WIDTH - 1,
    parameter int unsigned STEP_WIDTH  = 4,
    parameter int unsigned SATURATE    = 0
) (
    input  logic [COUNT_WIDTH-1:0] count,
    input  op_e                    op,
    input  dir_e                   dir,
    input  logic [STEP_WIDTH-1:0]  step,
    output logic [COUNT_WIDTH-1:0] next_count,
    output logic                   ovf_next,
    output logic                   unf_next
);

    // Two guard bits: holds count + step and count + modulus without truncation
    localparam int unsigned SUM_WIDTH = COUNT_WIDTH + 2;
    localparam logic [SUM_WIDTH-1:0] LIMIT   = SUM_WIDTH'(MAX_COUNT);
    localparam logic [SUM_WIDTH-1:0] MODULUS = SUM_WIDTH'(MAX_COUNT) + SUM_WIDTH'(1);

    logic [SUM_WIDTH-1:0] w_count_ext;
    logic [SUM_WIDTH-1:0] w_step_ext;
    logic [SUM_WIDTH-1:0] w_sum;

    assign w_count_ext = SUM_WIDTH'(count);
    assign w_step_ext  = SUM_WIDTH'(step);
    assign w_sum       = w_count_ext + w_step_ext;

    always_comb begin
        next_count = count;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (op == OP_COUNT) begin
            if (dir == DIR_UP) begin
                if (w_sum <= LIMIT) begin
                    next_count = COUNT_WIDTH'(w_sum);
                end else if (SATURATE == 0) begin
                    next_count = COUNT_WIDTH'(w_sum - MODULUS);
                    ovf_next   = 1'b1;
                end else begin
                    next_count = COUNT_WIDTH'(MAX_COUNT);
                    ovf_next   = (w_count_ext < LIMIT);
                end
            end else begin
                if (w_step_ext <= w_count_ext) begin
                    next_count = COUNT_WIDTH'(w_count_ext - w_step_ext);
                end else if (SATURATE == 0) begin
                    next_count = COUNT_WIDTH'(w_count_ext + MODULUS - w_step_ext);
                    unf_next   = 1'b1;
                end else begin
                    next_count = '0;
                    unf_next   = (count != '0);
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Modulo-N up/down counter with variable step, clear, load and wrap/saturate handling.
// Define UPDN_COUNTER_CMP_EN to build the cmp_hit compare; otherwise cmp_hit is tied low.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned MAX_COUNT   = 2**COUNT_WIDTH - 1,
    parameter int unsigned STEP_WIDTH  = 4,
    parameter int unsigned SATURATE    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    input  logic                   en,
    input  logic                   dir,
    input  logic [STEP_WIDTH-1:0]  step,
    input  logic [COUNT_WIDTH-1:0] cmp_value,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   ovf,
    output logic                   unf,
    output logic                   at_max,
    output logic                   at_zero,
    output logic                   cmp_hit
);

    if (((longint'(1) << STEP_WIDTH) - 1) > (longint'(MAX_COUNT) + 1)) begin : g_step_chk
        $error("updown_counter: STEP_WIDTH too wide for MAX_COUNT");
    end
    if (longint'(MAX_COUNT) > ((longint'(1) << COUNT_WIDTH) - 1)) begin : g_max_chk
        $error("updown_counter: MAX_COUNT does not fit in COUNT_WIDTH");
    end

    localparam logic [COUNT_WIDTH-1:0] MAX_VAL = COUNT_WIDTH'(MAX_COUNT);

    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_ovf;
    logic                   r_unf;
    logic                   r_at_max;
    logic                   r_at_zero;

    op_e                    w_op;
    logic [COUNT_WIDTH-1:0] w_arith_count;
    logic [COUNT_WIDTH-1:0] w_load_clamped;
    logic [COUNT_WIDTH-1:0] w_next_count;
    logic                   w_ovf_next;
    logic                   w_unf_next;

    assign w_op           = decode_op(clear, load, en);
    assign w_load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;

    updown_counter_next #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .MAX_COUNT   (MAX_COUNT),
        .STEP_WIDTH  (STEP_WIDTH),
        .SATURATE    (SATURATE)
    ) u_next (
        .count      (r_count),
        .op         (w_op),
        .dir        (dir_e'(dir)),
        .step       (step),
        .next_count (w_arith_count),
        .ovf_next   (w_ovf_next),
        .unf_next   (w_unf_next)
    );

    always_comb begin
        w_next_count = w_arith_count;
        unique case (w_op)
            OP_CLEAR: w_next_count = '0;
            OP_LOAD:  w_next_count = w_load_clamped;
            default:  w_next_count = w_arith_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_at_max  <= (MAX_COUNT == 0);
            r_at_zero <= 1'b1;
        end else begin
            r_count   <= w_next_count;
            r_ovf     <= w_ovf_next;
            r_unf     <= w_unf_next;
            r_at_max  <= (w_next_count == MAX_VAL);
            r_at_zero <= (w_next_count == '0);
        end
    end

`ifdef UPDN_COUNTER_CMP_EN
    logic r_cmp_hit;

    // Fires only on a change into cmp_value, so a hold never re-triggers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_hit <= 1'b0;
        end else begin
            r_cmp_hit <= (w_next_count == cmp_value) && (w_next_count != r_count);
        end
    end

    assign cmp_hit = r_cmp_hit;
`else
    logic w_cmp_unused;

    assign w_cmp_unused = ^cmp_value;
    assign cmp_hit      = 1'b0;
`endif

    assign count   = r_count;
    assign ovf     = r_ovf;
    assign unf     = r_unf;
    assign at_max  = r_at_max;
    assign at_zero = r_at_zero;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: a wrapping and a saturating instance (width 4, max 9,
// step width 3) share one stimulus stream; expected values are hand-computed per step.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       load;
    logic [3:0] load_value;
    logic       en;
    logic       dir;
    logic [2:0] step;
    logic [3:0] cmp_value;

    logic [3:0] w_count, s_count;
    logic       w_ovf, w_unf, w_at_max, w_at_zero, w_cmp_hit;
    logic       s_ovf, s_unf, s_at_max, s_at_zero, s_cmp_hit;

    int total = 0;
    int bad   = 0;

`ifdef UPDN_COUNTER_CMP_EN
    localparam logic CMP_ON = 1'b1;
`else
    localparam logic CMP_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    updown_counter #(
        .COUNT_WIDTH (4),
        .MAX_COUNT   (9),
        .STEP_WIDTH  (3),
        .SATURATE    (0)
    ) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .en         (en),
        .dir        (dir),
        .step       (step),
        .cmp_value  (cmp_value),
        .count      (w_count),
        .ovf        (w_ovf),
        .unf        (w_unf),
        .at_max     (w_at_max),
        .at_zero    (w_at_zero),
        .cmp_hit    (w_cmp_hit)
    );

    updown_counter #(
        .COUNT_WIDTH (4),
        .MAX_COUNT   (9),
        .STEP_WIDTH  (3),
        .SATURATE    (1)
    ) u_sat (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .en         (en),
        .dir        (dir),
        .step       (step),
        .cmp_value  (cmp_value),
        .count      (s_count),
        .ovf        (s_ovf),
        .unf        (s_unf),
        .at_max     (s_at_max),
        .at_zero    (s_at_zero),
        .cmp_hit    (s_cmp_hit)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count plus the two pulses; the level flags follow from the expected count
    task automatic chk_w(input string tag, input int c, input logic o, input logic u);
        check({tag, " wrap count"}, {4'b0, w_count}, 8'(c));
        check({tag, " wrap ovf"}, {7'b0, w_ovf}, {7'b0, o});
        check({tag, " wrap unf"}, {7'b0, w_unf}, {7'b0, u});
        check({tag, " wrap at_max"}, {7'b0, w_at_max}, {7'b0, (c == 9)});
        check({tag, " wrap at_zero"}, {7'b0, w_at_zero}, {7'b0, (c == 0)});
    endtask

    task automatic chk_s(input string tag, input int c, input logic o, input logic u);
        check({tag, " sat count"}, {4'b0, s_count}, 8'(c));
        check({tag, " sat ovf"}, {7'b0, s_ovf}, {7'b0, o});
        check({tag, " sat unf"}, {7'b0, s_unf}, {7'b0, u});
        check({tag, " sat at_max"}, {7'b0, s_at_max}, {7'b0, (c == 9)});
        check({tag, " sat at_zero"}, {7'b0, s_at_zero}, {7'b0, (c == 0)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cl, input logic ld, input logic [3:0] lv, input logic e,
                         input logic d, input logic [2:0] st);
        clear      = cl;
        load       = ld;
        load_value = lv;
        en         = e;
        dir        = d;
        step       = st;
    endtask

    initial begin
        rst       = 1'b1;
        cmp_value = 4'd15;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        tick();
        chk_w("reset", 0, 1'b0, 1'b0);
        chk_s("reset", 0, 1'b0, 1'b0);
        check("reset wrap cmp_hit", {7'b0, w_cmp_hit}, 8'd0);

        // Count up by 1 through the wrap point
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_w($sformatf("up1 #%0d", i), i % 10, (i == 10), 1'b0);
            chk_s($sformatf("up1 #%0d", i), (i > 9) ? 9 : i, 1'b0, 1'b0);
        end

        drive(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 3'd0);
        tick();
        chk_w("load8", 8, 1'b0, 1'b0);
        chk_s("load8", 8, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd3);
        tick();
        chk_w("8 up3", 1, 1'b1, 1'b0);
        chk_s("8 up3", 9, 1'b1, 1'b0);
        tick();
        chk_w("1 up3", 4, 1'b0, 1'b0);
        chk_s("9 up3", 9, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        tick();
        chk_w("clear", 0, 1'b0, 1'b0);
        chk_s("clear", 0, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd2);
        tick();
        chk_w("0 dn2", 8, 1'b0, 1'b1);
        chk_s("0 dn2", 0, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 3'd0);
        tick();
        chk_w("load1", 1, 1'b0, 1'b0);
        chk_s("load1", 1, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd5);
        tick();
        chk_w("1 dn5", 6, 1'b0, 1'b1);
        chk_s("1 dn5", 0, 1'b0, 1'b1);

        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd0);
        tick();
        chk_w("step0", 6, 1'b0, 1'b0);
        chk_s("step0", 0, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 3'd0);
        tick();
        chk_w("load9", 9, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd1);
        tick();
        chk_w("9 up1", 0, 1'b1, 1'b0);
        chk_s("9 up1", 9, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd1);
        tick();
        chk_w("en0 hold", 0, 1'b0, 1'b0);

        // Priority: clear wins over load and en, then load wins over en and clamps
        drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 3'd1);
        tick();
        chk_w("clr+ld+en", 0, 1'b0, 1'b0);
        chk_s("clr+ld+en", 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 3'd1);
        tick();
        chk_w("load15", 9, 1'b0, 1'b0);
        chk_s("load15", 9, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 3'd1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd1);
        tick();
        chk_w("5 up1", 6, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk_w("rst mid", 0, 1'b0, 1'b0);
        chk_s("rst mid", 0, 1'b0, 1'b0);

        // Compare pulse
        rst       = 1'b0;
        cmp_value = 4'd4;
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd2);
        tick();
        chk_w("cmp 0->2", 2, 1'b0, 1'b0);
        check("cmp 0->2 hit", {7'b0, w_cmp_hit}, 8'd0);
        tick();
        chk_w("cmp 2->4", 4, 1'b0, 1'b0);
        check("cmp 2->4 hit", {7'b0, w_cmp_hit}, {7'b0, CMP_ON});
        check("cmp 2->4 sat hit", {7'b0, s_cmp_hit}, {7'b0, CMP_ON});
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd2);
        tick();
        check("cmp hold hit", {7'b0, w_cmp_hit}, 8'd0);
        drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 3'd0);
        tick();
        check("cmp reload hit", {7'b0, w_cmp_hit}, 8'd0);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0);
        tick();
        check("cmp clear hit", {7'b0, w_cmp_hit}, 8'd0);
        drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 3'd0);
        tick();
        chk_w("cmp load4", 4, 1'b0, 1'b0);
        check("cmp load4 hit", {7'b0, w_cmp_hit}, {7'b0, CMP_ON});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
